// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: register map, bit indices,
// bus FSM states, interrupt-acknowledge address match and a byte-lane merge helper.
package interval_timer_pkg;

  // Word register index taken from ADDR[2:1]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RELOAD = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_ONESHOT = 2;

  // STATUS bit positions
  localparam int STAT_PEND = 0;

  // 68000 IACK cycles place all ones on A23..A4
  localparam logic [19:0] IACK_ADDR_HI = 20'hFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_IACK = 2'd2
  } bus_state_t;

  // Replace only the byte lanes whose strobe is active
  function automatic logic [15:0] lane_merge(input logic [15:0] old,
                                             input logic [15:0] wdata,
                                             input logic        uds,
                                             input logic        lds);
    lane_merge = {uds ? wdata[15:8] : old[15:8],
                  lds ? wdata[7:0]  : old[7:0]};
  endfunction

endpackage

// File: rtl/interval_timer_prescaler.sv
// Tick prescaler: counts 0..PRESCALE-1 while enabled, pulses tick on the
// terminal value, and sits at 0 while disabled.
module timer_prescaler #(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int             W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0]   TERM = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  // Free-running divider, cleared whenever the timer is off or wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (!en || tick)   cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/interval_timer.sv
// Memory-mapped periodic/one-shot interval timer with 68000 bus handshake
// and autovectored interrupt. Optional one-shot mode is built when
// INTERVAL_TIMER_ONESHOT_EN is defined; otherwise the timer is periodic only.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'hFF0000,
  parameter logic [2:0]  IPL_LEVEL = 3'd6,
  parameter int          PRESCALE  = 8
) (
  input  logic        CPUCLK_IN,
  input  logic        RESET_n_IN,
  input  logic        AS_IN,
  input  logic        WR_IN,
  input  logic        UDS_IN,
  input  logic        LDS_IN,
  input  logic [23:0] ADDR_IN,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        DTACK,
  output logic [2:0]  IPL,
  output logic        AVEC
);

  bus_state_t  state;
  logic        en, ie, oneshot, pend;
  logic [15:0] reload, count;
  logic [15:0] rd_data;
  logic        tick;

  // A0 is not part of a word-register address
  logic unused_a0;
  assign unused_a0 = ADDR_IN[0];

  // Address decode; the window and the IACK space never overlap
  logic       sel_win, iack_hit, bus_go, iack_go, wr_go, iack_done, expire;
  logic [1:0] reg_sel;

  assign reg_sel   = ADDR_IN[2:1];
  assign sel_win   = (ADDR_IN[23:3] == BASE_ADDR[23:3]);
  assign iack_hit  = AS_IN && !WR_IN && (ADDR_IN[23:4] == IACK_ADDR_HI)
                     && (ADDR_IN[3:1] == IPL_LEVEL);
  assign bus_go    = (state == ST_IDLE) && AS_IN && sel_win && (UDS_IN || LDS_IN);
  assign iack_go   = (state == ST_IDLE) && iack_hit;
  assign wr_go     = bus_go && WR_IN;
  assign iack_done = (state == ST_IACK) && !AS_IN;
  assign expire    = tick && (count == 16'h0000);

  // Per-register write strobes, one per bus cycle
  logic wr_ctrl, wr_reload, clr_pend;
  assign wr_ctrl   = wr_go && (reg_sel == REG_CTRL) && LDS_IN;
  assign wr_reload = wr_go && (reg_sel == REG_RELOAD);
  assign clr_pend  = (wr_go && (reg_sel == REG_STATUS) && LDS_IN && DATA_IN[STAT_PEND])
                     || iack_done;

  timer_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (CPUCLK_IN),
    .rst_n (RESET_n_IN),
    .en    (en),
    .tick  (tick)
  );

  // Register read mux; unused bits read as zero
  always_comb begin
    rd_data = 16'h0000;
    case (reg_sel)
      REG_CTRL:   rd_data = {13'h0, oneshot, ie, en};
      REG_STATUS: rd_data = {15'h0, pend};
      REG_RELOAD: rd_data = reload;
      REG_COUNT:  rd_data = count;
      default:    rd_data = 16'h0000;
    endcase
  end

`ifdef INTERVAL_TIMER_ONESHOT_EN
  // One-shot mode bit, low byte lane only
  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN)  oneshot <= 1'b0;
    else if (wr_ctrl) oneshot <= DATA_IN[CTRL_ONESHOT];
  end
`else
  assign oneshot = 1'b0;
`endif

  // CTRL enable/interrupt-enable; a one-shot expiry overrides a same-cycle write
  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      en <= 1'b0;
      ie <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en <= DATA_IN[CTRL_EN];
        ie <= DATA_IN[CTRL_IE];
      end
      if (expire && oneshot) en <= 1'b0;
    end
  end

  // RELOAD register and the down-counter; a disabled timer loads COUNT directly
  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      reload <= 16'hFFFF;
      count  <= 16'hFFFF;
    end else begin
      if (wr_reload) reload <= lane_merge(reload, DATA_IN, UDS_IN, LDS_IN);
      if (tick)
        count <= expire ? reload : count - 16'd1;
      else if (wr_reload && !en)
        count <= lane_merge(reload, DATA_IN, UDS_IN, LDS_IN);
    end
  end

  // Pending flag: expiry beats a simultaneous clear (W1C or IACK completion)
  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN)   pend <= 1'b0;
    else if (expire)   pend <= 1'b1;
    else if (clr_pend) pend <= 1'b0;
  end

  // Registered interrupt level, follows PEND/IE one cycle later
  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) IPL <= 3'd0;
    else             IPL <= (pend && ie) ? IPL_LEVEL : 3'd0;
  end

  // Bus FSM with registered DTACK/AVEC/read data, released when AS drops
  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      state    <= ST_IDLE;
      DTACK    <= 1'b0;
      AVEC     <= 1'b0;
      DATA_OE  <= 1'b0;
      DATA_OUT <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus_go) begin
            state    <= ST_ACK;
            DTACK    <= 1'b1;
            DATA_OE  <= !WR_IN;
            DATA_OUT <= WR_IN ? 16'h0000 : rd_data;
          end else if (iack_go) begin
            state <= ST_IACK;
            AVEC  <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!AS_IN) begin
            state   <= ST_IDLE;
            DTACK   <= 1'b0;
            DATA_OE <= 1'b0;
          end
        end
        ST_IACK: begin
          if (!AS_IN) begin
            state <= ST_IDLE;
            AVEC  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          DTACK   <= 1'b0;
          AVEC    <= 1'b0;
          DATA_OE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: register reset values, period timing,
// W1C vs expiry priority, IACK/AVEC handling, one-shot, byte lanes, reset mid-cycle.
module tb_interval_timer;

  localparam logic [23:0] A_CTRL = 24'hFF0000;
  localparam logic [23:0] A_STAT = 24'hFF0002;
  localparam logic [23:0] A_REL  = 24'hFF0004;
  localparam logic [23:0] A_CNT  = 24'hFF0006;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        as_s = 1'b0, wr = 1'b0, uds = 1'b0, lds = 1'b0;
  logic [23:0] addr = 24'h0;
  logic [15:0] wdata = 16'h0;
  logic [15:0] data_out;
  logic        data_oe, dtack, avec;
  logic [2:0]  ipl;
  logic [15:0] rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  interval_timer #(
    .BASE_ADDR (24'hFF0000),
    .IPL_LEVEL (3'd6),
    .PRESCALE  (8)
  ) dut (
    .CPUCLK_IN  (clk),
    .RESET_n_IN (rst_n),
    .AS_IN      (as_s),
    .WR_IN      (wr),
    .UDS_IN     (uds),
    .LDS_IN     (lds),
    .ADDR_IN    (addr),
    .DATA_IN    (wdata),
    .DATA_OUT   (data_out),
    .DATA_OE    (data_oe),
    .DTACK      (dtack),
    .IPL        (ipl),
    .AVEC       (avec)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle, started and finished on a falling clock edge
  task automatic bus_cycle(input logic [23:0] a, input logic w, input logic [15:0] d,
                           input logic u, input logic l, input int hold,
                           output logic [15:0] rdata);
    addr = a; wr = w; wdata = d; uds = u; lds = l; as_s = 1'b1;
    @(negedge clk);
    check("dtack_rise", 16'(dtack), 16'h1);
    check("data_oe_ack", 16'(data_oe), 16'(!w));
    rdata = data_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("dtack_hold", 16'(dtack), 16'h1);
    end
    as_s = 1'b0;
    @(negedge clk);
    check("dtack_drop", 16'(dtack), 16'h0);
    check("data_oe_drop", 16'(data_oe), 16'h0);
  endtask

  task automatic wr16(input logic [23:0] a, input logic [15:0] d);
    logic [15:0] dummy;
    bus_cycle(a, 1'b1, d, 1'b1, 1'b1, 0, dummy);
  endtask

  task automatic rd_chk(input logic [23:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] v;
    bus_cycle(a, 1'b0, 16'h0, 1'b1, 1'b1, 0, v);
    check(tag, v, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ipl", 16'(ipl), 16'h0);
    check("rst_dtack", 16'(dtack), 16'h0);
    check("rst_avec", 16'(avec), 16'h0);
    check("rst_oe", 16'(data_oe), 16'h0);
    check("rst_dout", data_out, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk(A_CTRL, 16'h0000, "rst_ctrl");
    rd_chk(A_STAT, 16'h0000, "rst_status");
    rd_chk(A_REL,  16'hFFFF, "rst_reload");
    rd_chk(A_CNT,  16'hFFFF, "rst_count");

    // Periodic: RELOAD=3, PRESCALE=8 -> expiry 32 cycles after enable commit
    wr16(A_REL, 16'h0003);
    rd_chk(A_CNT, 16'h0003, "count_load");
    wr16(A_CTRL, 16'h0003);            // commit edge P1, returns at N2
    repeat (31) @(negedge clk);        // N33: expiry at P33 not yet visible on IPL
    check("ipl_before_exp1", 16'(ipl), 16'h0);
    @(negedge clk);                    // N34
    check("ipl_exp1", 16'(ipl), 16'h6);
    wr16(A_STAT, 16'h0001);            // clear at P35, returns N36
    check("ipl_w1c", 16'(ipl), 16'h0);
    repeat (29) @(negedge clk);        // N65
    check("ipl_before_exp2", 16'(ipl), 16'h0);
    @(negedge clk);                    // N66
    check("ipl_exp2", 16'(ipl), 16'h6);

    // Clear write lands on the expiry edge P97: expiry wins
    repeat (30) @(negedge clk);        // N96
    wr16(A_STAT, 16'h0001);
    wr16(A_CTRL, 16'h0002);            // stop timer, keep IE
    rd_chk(A_STAT, 16'h0001, "pend_wins");
    rd_chk(A_CTRL, 16'h0002, "ctrl_ie_only");
    rd_chk(A_CNT,  16'h0003, "count_reloaded");

    // IACK at level 5: ignored
    addr = 24'hFFFFFA; wr = 1'b0; uds = 1'b1; lds = 1'b1; as_s = 1'b1;
    repeat (2) @(negedge clk);
    check("iack5_avec", 16'(avec), 16'h0);
    check("iack5_dtack", 16'(dtack), 16'h0);
    as_s = 1'b0;
    @(negedge clk);
    check("iack5_ipl", 16'(ipl), 16'h6);

    // IACK at level 6: AVEC, then PEND clears when AS drops
    addr = 24'hFFFFFC; as_s = 1'b1;
    @(negedge clk);
    check("iack6_avec", 16'(avec), 16'h1);
    check("iack6_dtack", 16'(dtack), 16'h0);
    @(negedge clk);
    check("iack6_avec_hold", 16'(avec), 16'h1);
    as_s = 1'b0;
    @(negedge clk);
    check("iack6_avec_drop", 16'(avec), 16'h0);
    check("iack6_ipl_lag", 16'(ipl), 16'h6);
    @(negedge clk);
    check("iack6_ipl_clr", 16'(ipl), 16'h0);
    rd_chk(A_STAT, 16'h0000, "iack6_pend_clr");

    // One-shot: RELOAD=0, CTRL=7
    wr16(A_REL, 16'h0000);
    wr16(A_CTRL, 16'h0007);
    repeat (20) @(negedge clk);
    rd_chk(A_STAT, 16'h0001, "os_pend");
`ifdef INTERVAL_TIMER_ONESHOT_EN
    rd_chk(A_CTRL, 16'h0006, "os_ctrl");
`else
    rd_chk(A_CTRL, 16'h0003, "os_ctrl");
`endif
    wr16(A_STAT, 16'h0001);
    repeat (20) @(negedge clk);
`ifdef INTERVAL_TIMER_ONESHOT_EN
    rd_chk(A_STAT, 16'h0000, "os_no_repeat");
`else
    rd_chk(A_STAT, 16'h0001, "os_repeat");
`endif
    wr16(A_CTRL, 16'h0000);

    // Byte lanes: LDS-only CTRL write with DTACK held while AS stays asserted
    bus_cycle(A_CTRL, 1'b1, 16'hFF03, 1'b0, 1'b1, 3, rd);
    rd_chk(A_CTRL, 16'h0003, "ctrl_lds");
    wr16(A_CTRL, 16'h0000);
    wr16(A_REL, 16'h1234);
    bus_cycle(A_REL, 1'b1, 16'hAB99, 1'b1, 1'b0, 0, rd);
    rd_chk(A_REL, 16'hAB34, "reload_uds");
    rd_chk(A_CNT, 16'hAB34, "count_uds");

    // Reset while in ACK: everything back to idle/reset values
    addr = A_REL; wr = 1'b0; uds = 1'b1; lds = 1'b1; as_s = 1'b1;
    @(negedge clk);
    check("mid_dtack", 16'(dtack), 16'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_dtack", 16'(dtack), 16'h0);
    check("rst_mid_oe", 16'(data_oe), 16'h0);
    as_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_idle", 16'(dtack), 16'h0);
    rd_chk(A_REL, 16'hFFFF, "rst_mid_reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Memory-mapped periodic/one-shot interval timer for the 68000 board glue. It replaces the constant-zero IPL/AVEC ties at the top level with a real level-N autovectored interrupt source. It decodes its own register window, answers bus cycles with DTACK and read data alongside BusControl, and detects the 68000 interrupt-acknowledge cycle to assert AVEC.

## Interface
Parameters:
- BASE_ADDR, 24'hFF0000, register window base (8 bytes, word registers at +0,+2,+4,+6)
- IPL_LEVEL, 3'd6, interrupt level driven on IPL when pending and enabled
- PRESCALE, 8, CPUCLK cycles per timer tick (≥1)

Ports (active-high internally; top level inverts):
- CPUCLK_IN  in  1  the single clock; all state on rising edge
- RESET_n_IN  in  1  asynchronous, active-low reset
- AS_IN  in  1  address strobe
- WR_IN  in  1  1 = write cycle
- UDS_IN, LDS_IN  in  1 each  byte-lane strobes (UDS = D15..8)
- ADDR_IN  in  24  CPU address
- DATA_IN  in  16  CPU write data
- DATA_OUT  out  16  read data
- DATA_OE  out  1  drive DATA_OUT onto bus
- DTACK  out  1  register-cycle acknowledge
- IPL  out  3  interrupt level (0 = none)
- AVEC  out  1  autovector request during matching IACK

## Operation
- Registers: CTRL (+0) bit0 EN, bit1 IE, bit2 ONESHOT; STATUS (+2) bit0 PEND, write-1-to-clear; RELOAD (+4) 16 bit; COUNT (+6) read-only. Unused bits read 0.
- Byte writes honour UDS/LDS individually; no lane = no write.
- Prescaler counts 0..PRESCALE-1 while EN=1; tick on terminal value; held at 0 while EN=0.
- On tick: COUNT==0 → expire (PEND←1, COUNT←RELOAD, ONESHOT clears EN); else COUNT←COUNT-1. Period = (RELOAD+1)·PRESCALE cycles; RELOAD=0 expires every tick.
- Writing RELOAD while EN=0 also loads COUNT; while EN=1 it takes effect at next expiry.
- IPL = (PEND & IE) ? IPL_LEVEL : 0.
- IACK: AS & ~WR & ADDR[23:4]==all ones & ADDR[3:1]==IPL_LEVEL → AVEC; PEND cleared when that AS deasserts. Non-matching level: no response.
- Bus FSM: IDLE → (AS & decode & (UDS|LDS) sampled) ACK → (AS low) IDLE. Window and IACK are mutually exclusive decodes.

## Timing
- Reset: DATA_OUT=0, DATA_OE=0, DTACK=0, IPL=0, AVEC=0, CTRL=0, STATUS=0, RELOAD=COUNT=16'hFFFF, prescaler=0, FSM IDLE.
- DTACK/AVEC assert one cycle after qualifying AS sample; held until AS deasserts, drop the cycle after.
- Write commits on the IDLE→ACK edge, exactly once per bus cycle.
- Read data latched on IDLE→ACK edge; DATA_OE = ACK & ~WR.
- IPL changes the cycle after PEND or IE changes.
- Expiry in same cycle as STATUS clear write: expiry wins, PEND stays 1.
- AS drop mid-ACK with reset: reset dominates, FSM IDLE.

## Configuration
- INTERVAL_TIMER_ONESHOT_EN defined: CTRL bit2 implemented as above.
- Undefined: bit2 not stored, reads 0, timer is periodic only; no other behaviour changes.

## Structure
- Package interval_timer_pkg: register offsets, CTRL/STATUS bit indices, bus FSM state enum, IACK address-match constant.
- One sub-module: timer_prescaler (PRESCALE counter, EN input, tick output).

## Test plan
- Reset, read all four registers → CTRL=0000, STATUS=0000, RELOAD=FFFF, COUNT=FFFF; IPL=0.
- PRESCALE=8, RELOAD=3, CTRL=0003 → PEND sets every 32 cycles, IPL=6 within 1 cycle of expiry.
- IACK at ADDR=FFFFFC (A3..A1=6) while pending → AVEC one cycle after AS, PEND cleared after AS drops, IPL→0; level-5 IACK → no AVEC.
- Write STATUS=0001 on expiry cycle → PEND remains 1.
- ONESHOT (macro on), RELOAD=0, CTRL=0007 → single expiry, EN reads 0; macro off → repeated expiries.
- Write CTRL with LDS only, data 0xFF03 → CTRL low byte updated, upper lane untouched; DTACK held until AS drops.
